// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, replayer FSM states and grid geometry.
package maze_pkg;

  localparam int unsigned COORD_W = 4;
  localparam logic [COORD_W-1:0] GOAL_XY = '1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    MOVE    = 3'd2,
    PRESENT = 3'd3,
    PACE    = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/coord_stepper.sv
// Combinational single-move stepper: applies one direction to (x,y) and flags
// a move that would leave the grid.
module coord_stepper #(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [1:0]         dir_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               out_of_range_o
);
  import maze_pkg::*;

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] x_ext;
  logic [EXT_W-1:0] y_ext;

  // One extra bit catches both carry past max and borrow below zero.
  always_comb begin
    x_ext = {1'b0, x_i};
    y_ext = {1'b0, y_i};
    case (dir_i)
      DIR_UP:    y_ext = {1'b0, y_i} - EXT_W'(1);
      DIR_RIGHT: x_ext = {1'b0, x_i} + EXT_W'(1);
      DIR_LEFT:  x_ext = {1'b0, x_i} - EXT_W'(1);
      DIR_DOWN:  y_ext = {1'b0, y_i} + EXT_W'(1);
      default:   ;
    endcase
    x_o            = x_ext[COORD_W-1:0];
    y_o            = y_ext[COORD_W-1:0];
    out_of_range_o = x_ext[COORD_W] | y_ext[COORD_W];
  end

endmodule

// File: rtl/route_replayer.sv
// Replays a solved-path direction stream as a paced sequence of grid positions
// offered to a downstream consumer over valid/ready.
module route_replayer #(
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned STEP_W      = 9,
  parameter int unsigned PACE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         q_dir,
  input  logic               q_finish,
  output logic               q_dequeue,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               goal,
  output logic               err
);
  import maze_pkg::*;

  localparam int unsigned PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

  state_e              state_q;
  logic [1:0]          dir_q;
  logic [COORD_W-1:0]  x_q;
  logic [COORD_W-1:0]  y_q;
  logic [STEP_W-1:0]   step_q;
  logic [PACE_W-1:0]   pace_q;
  logic                pos_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                goal_q;
  logic                err_q;

  logic [COORD_W-1:0]  x_d;
  logic [COORD_W-1:0]  y_d;
  logic                oor_c;

  coord_stepper #(.COORD_W(COORD_W)) u_stepper (
    .x_i            (x_q),
    .y_i            (y_q),
    .dir_i          (dir_q),
    .x_o            (x_d),
    .y_o            (y_d),
    .out_of_range_o (oor_c)
  );

  // The pop must coincide with the cycle the head is latched, so it follows FETCH directly.
  assign q_dequeue  = (state_q == FETCH) && !q_finish && !rst;
  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign pos_valid  = pos_valid_q;
  assign step_count = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign goal       = goal_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 2'b00;
      x_q         <= '0;
      y_q         <= '0;
      step_q      <= '0;
      pace_q      <= '0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      goal_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            x_q     <= '0;
            y_q     <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
            goal_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (q_finish) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            goal_q  <= (&x_q) && (&y_q);
            state_q <= DONE;
          end else begin
            dir_q   <= q_dir;
            state_q <= MOVE;
          end
        end
        MOVE: begin
          if (oor_c) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            if (step_q != '1) step_q <= step_q + STEP_W'(1);
            pos_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (pos_ready) begin
            pos_valid_q <= 1'b0;
            pace_q      <= PACE_W'(PACE_CYCLES - 1);
            state_q     <= PACE;
          end
        end
        PACE: begin
          if (pace_q == '0) state_q <= FETCH;
          else              pace_q  <= pace_q - PACE_W'(1);
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/route_replayer.md
Name: route_replayer

Overview:
- Consumes the solved-path direction stream that the rat datapath's path queue produces, one 2-bit move per dequeue.
- Rebuilds the rat's coordinate trajectory from (0,0) and presents each position to a downstream consumer (display/checker) through a valid/ready handshake.
- Paces moves with a programmable dwell timer and flags completion, goal reached, and illegal moves.

Parameters:
- COORD_W, 4, coordinate width; grid spans 0..2^COORD_W-1.
- STEP_W, 9, step counter width; must hold 2^(2*COORD_W).
- PACE_CYCLES, 4, dwell cycles after each accepted position; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a replay from IDLE or DONE.
- q_dir  in  2  head-of-queue direction; valid whenever q_finish=0.
- q_finish  in  1  queue exhausted; q_dir is not meaningful.
- q_dequeue  out  1  pop request; queue advances on this clk edge.
- pos_x  out  COORD_W  current x coordinate.
- pos_y  out  COORD_W  current y coordinate.
- pos_valid  out  1  pos_x/pos_y hold a new position.
- pos_ready  in  1  consumer accepts the position.
- step_count  out  STEP_W  moves applied since start.
- busy  out  1  replay in progress.
- done  out  1  replay finished, level, held until next start.
- goal  out  1  valid with done; the final position is all-ones in both axes.
- err  out  1  a move left the grid; replay aborted, level.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pos_x=pos_y=0; step_count=0; q_dequeue, pos_valid, busy, done, goal and err all 0. Reset wins over every other input in the same cycle. Reset mid-replay aborts without a dequeue in that cycle.
- Direction encoding: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- FSM states: IDLE, FETCH, MOVE, PRESENT, PACE, DONE, ERR.
- IDLE: on start, clear x, y, step_count, done, goal and err, then go to FETCH. busy=1 in every state except IDLE, DONE and ERR.
- FETCH:
  - If q_finish=1, go to DONE; q_dequeue stays 0.
  - Otherwise latch q_dir into dir_reg, pulse q_dequeue for exactly this cycle, and go to MOVE.
- MOVE:
  - Compute the next position with a COORD_W+1-bit add or subtract.
  - A carry or borrow out of range means the move leaves the grid: go to ERR and leave x, y and step_count unchanged.
  - Otherwise register the new x/y, increment step_count (saturating at all-ones), and go to PRESENT.
- PRESENT: pos_valid=1 and the position is held stable. When pos_valid&&pos_ready, go to PACE and load the pace counter with PACE_CYCLES-1. pos_valid must not drop before acceptance.
- PACE: decrement the counter each cycle; at 0, go to FETCH. The minimum move period is 3+PACE_CYCLES cycles with pos_ready tied high.
- DONE: done=1; goal=(pos_x==max && pos_y==max), evaluated on entry and held. A start pulse re-enters the IDLE-clear sequence directly, with the clear done in the same cycle. If the queue is empty at start, go directly to DONE with goal=0 and step_count=0.
- ERR: err=1; accept only start, which behaves as in DONE. q_dequeue is never asserted in ERR.
- Start while busy is ignored.
- Handshake: q_dequeue is asserted at most once per fetched direction and never while q_finish=1.

Decomposition:
- Shared package (maze_pkg):
  - direction codes DIR_UP/DIR_RIGHT/DIR_LEFT/DIR_DOWN;
  - FSM state enum;
  - COORD_W and the goal constant.
- One sub-module: coord_stepper. It is combinational: x, y and dir in; next x, next y and out_of_range out. It is reused by any later move-based stage.
- Pacing counter and step counter stay inline.

Test Plan:
- Queue holds [01,11,01,11], pos_ready=1, PACE_CYCLES=4:
  - pos_valid presents (1,0),(1,1),(2,1),(2,2);
  - exactly 4 q_dequeue pulses, 7 cycles apart;
  - done=1, goal=0, step_count=4.
- Path of 15x right then 15x down: final (15,15), goal=1, step_count=30, err=0.
- First direction 00 (up from y=0): err=1 two cycles after start; pos stays (0,0); no pos_valid; exactly one q_dequeue.
- pos_ready held low for 10 cycles during PRESENT: pos_valid stays high with a stable position; no further q_dequeue until the pos_ready cycle plus PACE.
- q_finish=1 at start: done=1 with no q_dequeue and step_count=0. A second start after refilling with [01] gives (1,0) and done.
- Reset asserted mid-PACE: next cycle all outputs are 0 and the state is IDLE. A subsequent start replays from (0,0).
